// File: rtl/irq_controller.sv
// Four-source interrupt controller with a memory-mapped register window.
// Rising edges on src latch into PEND (a repeat edge while still pending
// sets the sticky OVF bit). MASK gates arbitration, and the lowest-index
// eligible source wins. A three-state FSM raises irqout while a request
// waits for the CPU, then holds the selected id until software ACKs it.
module irq_controller #(
  parameter logic [31:0] BASE = 32'h40000040
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  src,
  input  logic        supervisor,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout,
  output logic [1:0]  irq_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  irq_id_nxt;
  logic [3:0]  src_q;
  logic [3:0]  pend, pend_nxt;
  logic [3:0]  ovf, ovf_nxt;
  logic [3:0]  mask;
  logic [3:0]  rise;
  logic [3:0]  eligible;
  logic [3:0]  ack_clr;
  logic [1:0]  winner;
  logic [1:0]  sel;
  logic        hit;
  logic        wr_mask;
  logic        wr_ack;
  logic        unused_bits;

  // Lowest index has the highest priority.
  function automatic logic [1:0] prio_winner(input logic [3:0] e);
    if (e[0])      return 2'd0;
    else if (e[1]) return 2'd1;
    else if (e[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // The window is 16 bytes, so the byte offset within a word is ignored.
  assign hit         = (addr[31:4] == BASE[31:4]);
  assign sel         = addr[3:2];
  assign wr_mask     = wr && hit && (sel == 2'd1);
  assign wr_ack      = wr && hit && (sel == 2'd2);
  assign ack_clr     = wr_ack ? wdata[3:0] : 4'h0;
  assign unused_bits = ^{wdata[31:4], addr[1:0]};

  // A new edge beats a simultaneous ACK for PEND, but the ACK still clears OVF.
  assign rise     = src & ~src_q;
  assign pend_nxt = (pend & ~ack_clr) | rise;
  assign ovf_nxt  = (ovf | (rise & pend)) & ~ack_clr;
  assign eligible = pend & mask;
  assign winner   = prio_winner(eligible);

  // Source sampling, pending/overflow bookkeeping and the mask register.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q <= 4'h0;
      pend  <= 4'h0;
      ovf   <= 4'h0;
      mask  <= 4'h0;
    end else begin
      src_q <= src;
      pend  <= pend_nxt;
      ovf   <= ovf_nxt;
      if (wr_mask) mask <= wdata[3:0];
    end
  end

  // Next state and selected id; REQ keeps re-arbitrating until the CPU takes the exception.
  always_comb begin
    state_nxt  = state;
    irq_id_nxt = irq_id;
    case (state)
      IDLE: begin
        if ((eligible != 4'h0) && !supervisor) begin
          state_nxt  = REQ;
          irq_id_nxt = winner;
        end
      end
      REQ: begin
        if (eligible == 4'h0) begin
          state_nxt = IDLE;
        end else if (supervisor) begin
          state_nxt = SERVICE;
        end else begin
          irq_id_nxt = winner;
        end
      end
      SERVICE: begin
        if (!pend_nxt[irq_id]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; irqout is registered alongside it so it mirrors state==REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      irq_id <= 2'd0;
      irqout <= 1'b0;
    end else begin
      state  <= state_nxt;
      irq_id <= irq_id_nxt;
      irqout <= (state_nxt == REQ);
    end
  end

  // Register read mux; ACK is write-only and reads back as zero.
  always_comb begin
    rdata = 32'h0;
    if (rd && hit) begin
      case (sel)
        2'd0:    rdata = {28'h0, pend};
        2'd1:    rdata = {28'h0, mask};
        2'd3:    rdata = {20'h0, ovf, 2'b00, state, 2'b00, irq_id};
        default: rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: each scenario queues the values it
// expects as it drives stimulus, and observations pop them in order.
module tb_irq_controller;

  localparam logic [31:0] BASE   = 32'h40000040;
  localparam logic [31:0] A_PEND = BASE;
  localparam logic [31:0] A_MASK = BASE + 32'h4;
  localparam logic [31:0] A_ACK  = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  src;
  logic        supervisor;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irqout;
  logic [1:0]  irq_id;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  irq_controller #(.BASE(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .src        (src),
    .supervisor (supervisor),
    .rd         (rd),
    .wr         (wr),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .irqout     (irqout),
    .irq_id     (irq_id)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: got 0x%0h, expected no observation", obs);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    rd   = 1'b1;
    #1;
    d    = rdata;
    rd   = 1'b0;
    #1;
  endtask

  task automatic obs_reg(input logic [31:0] a);
    logic [31:0] d;
    bus_read(a, d);
    sb_pop(d);
  endtask

  task automatic obs_irq();
    sb_pop({31'h0, irqout});
    sb_pop({30'h0, irq_id});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; src = 4'h0; supervisor = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    sb_push("rst_irqout", 0); sb_push("rst_irq_id", 0);
    sb_push("rst_stat", 0); sb_push("rst_mask", 0); sb_push("rst_pend", 0);
    obs_irq(); obs_reg(A_STAT); obs_reg(A_MASK); obs_reg(A_PEND);

    // Single pulse on src[2], all enabled
    bus_write(A_MASK, 32'hF);
    src = 4'b0100;
    sb_push("p2_pend", 32'h4); sb_push("p2_irqout_early", 0);
    tick();
    src = 4'h0;
    obs_reg(A_PEND); sb_pop({31'h0, irqout});
    sb_push("p2_irqout", 1); sb_push("p2_irq_id", 2); sb_push("p2_stat", 32'h12);
    tick();
    obs_irq(); obs_reg(A_STAT);

    // Higher priority arrival preempts while in REQ
    src = 4'b0001;
    tick();
    src = 4'h0;
    sb_push("pre_irqout", 1); sb_push("pre_irq_id", 0);
    tick();
    obs_irq();
    supervisor = 1'b1;
    sb_push("svc_irqout", 0); sb_push("svc_irq_id", 0); sb_push("svc_stat", 32'h20);
    tick();
    obs_irq(); obs_reg(A_STAT);

    // ACK ends service; src[2] is re-requested once supervisor drops
    sb_push("ack0_stat", 0); sb_push("ack0_pend", 32'h4);
    bus_write(A_ACK, 32'h1);
    obs_reg(A_STAT); obs_reg(A_PEND);
    supervisor = 1'b0;
    sb_push("rereq_irqout", 1); sb_push("rereq_irq_id", 2);
    tick();
    obs_irq();
    supervisor = 1'b1;
    tick();
    sb_push("ack2_irqout", 0); sb_push("ack2_pend", 0);
    bus_write(A_ACK, 32'h4);
    sb_pop({31'h0, irqout}); obs_reg(A_PEND);

    // Overflow: steady level gives no event, a second edge sets OVF[1]
    src = 4'b0010;
    tick(); tick();
    src = 4'h0;
    tick();
    sb_push("lvl_stat", 32'h002);
    obs_reg(A_STAT);
    src = 4'b0010;
    tick();
    src = 4'h0;
    tick();
    sb_push("ovf_pend", 32'h2); sb_push("ovf_stat", 32'h202);
    obs_reg(A_PEND); obs_reg(A_STAT);
    src = 4'b0010;
    sb_push("ackedge_pend", 32'h2); sb_push("ackedge_stat", 32'h002);
    bus_write(A_ACK, 32'h2);
    src = 4'h0;
    obs_reg(A_PEND); obs_reg(A_STAT);
    bus_write(A_ACK, 32'h2);

    // Masked source stays pending until enabled
    bus_write(A_MASK, 32'h0);
    supervisor = 1'b0;
    src = 4'b1000;
    tick();
    src = 4'h0;
    tick(); tick();
    sb_push("msk_pend", 32'h8); sb_push("msk_irqout", 0);
    obs_reg(A_PEND); sb_pop({31'h0, irqout});
    sb_push("unmsk_irqout0", 0);
    bus_write(A_MASK, 32'h8);
    sb_pop({31'h0, irqout});
    sb_push("unmsk_irqout", 1); sb_push("unmsk_irq_id", 3);
    sb_push("rd_pend", 32'h8); sb_push("rd_mask_lowbits", 32'h8); sb_push("rd_idle_bus", 0);
    tick();
    obs_irq(); obs_reg(A_PEND); obs_reg(A_MASK + 32'h2);
    addr = A_PEND; rd = 1'b0; #1;
    sb_pop(rdata);

    // Reset during SERVICE, with a write in the reset cycle
    supervisor = 1'b1;
    tick();
    src = 4'b0001;
    tick();
    src = 4'h0;
    addr = A_MASK; wdata = 32'hF; wr = 1'b1; reset = 1'b1;
    tick();
    wr = 1'b0; reset = 1'b0;
    sb_push("rst2_irqout", 0); sb_push("rst2_irq_id", 0);
    sb_push("rst2_stat", 0); sb_push("rst2_mask", 0); sb_push("rst2_pend", 0);
    sb_push("unmapped", 0); sb_push("ack_read", 0);
    obs_irq(); obs_reg(A_STAT); obs_reg(A_MASK); obs_reg(A_PEND);
    obs_reg(BASE + 32'h10); obs_reg(A_ACK);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_leftover: got %0d entries, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
